sd_cmd_wb_master: RTL and testbench



---
 rtl/sd_ctrl_pkg.sv | 30 +++
 rtl/sd_crc7_byte.sv | 20 ++
 rtl/sd_cmd_wb_master.sv | 187 ++++++++++++++++++
 tb/tb_sd_cmd_wb_master.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_ctrl_pkg.sv
// Shared definitions for the SD controller command path: register map,
// status bit positions, response lengths and the command master FSM states.
package sd_ctrl_pkg;

    // Slave register addresses
    localparam logic [2:0] ADR_TX_CMD = 3'd0;
    localparam logic [2:0] ADR_RX_CMD = 3'd1;
    localparam logic [2:0] ADR_STATUS = 3'd4;
    localparam logic [2:0] ADR_TIMER  = 3'd6;

    // Status register bit positions
    localparam int unsigned STAT_TX_FULL  = 0;
    localparam int unsigned STAT_RX_EMPTY = 1;

    // Frame and response lengths in bytes
    localparam int unsigned FRAME_LEN     = 6;
    localparam int unsigned RSP_LEN_SHORT = 6;
    localparam int unsigned RSP_LEN_LONG  = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_TX,
        S_WR_TX,
        S_RX_STAT,
        S_RD_TIM,
        S_RD_RX,
        S_DONE
    } cmd_state_e;

endpackage

// File: rtl/sd_crc7_byte.sv
// One-byte step of the SD CRC7 (x^7 + x^3 + 1), MSB first, purely combinational.
module sd_crc7_byte (
    input  logic [6:0] i_crc,
    input  logic [7:0] i_data,
    output logic [6:0] o_crc
);

    logic w_fb;

    // Shift the eight data bits through the CRC register, MSB first
    always_comb begin
        o_crc = i_crc;
        w_fb  = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_fb  = o_crc[6] ^ i_data[3'(7 - i)];
            o_crc = {o_crc[5:0], 1'b0} ^ (w_fb ? 7'h09 : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_wb_master.sv
// Wishbone classic master that sends one SD command frame to the controller's
// tx command FIFO and streams the response bytes from the rx command FIFO.
module sd_cmd_wb_master
    import sd_ctrl_pkg::*;
#(
    parameter int unsigned ACK_WAIT_MAX = 15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic [2:0]  wbm_adr_o,
    output logic [7:0]  wbm_dat_o,
    input  logic [7:0]  wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        cmd_start_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_arg_i,
    input  logic [1:0]  rsp_type_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic        bus_err_o,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic [4:0]  rsp_cnt_o
);

    localparam int unsigned WAIT_W = $clog2(ACK_WAIT_MAX + 1);

    cmd_state_e        r_state;
    logic [5:0]        r_index;
    logic [31:0]       r_arg;
    logic              r_has_rsp;
    logic              r_rsp_long;
    logic [4:0]        r_cnt;
    logic [6:0]        r_crc;
    logic [WAIT_W-1:0] r_wait;

    logic [7:0]        w_tx_byte;
    logic [6:0]        w_crc_next;
    logic [4:0]        w_last;

    assign wbm_sel_o = 4'hF;
    assign w_last    = r_rsp_long ? 5'(RSP_LEN_LONG - 1) : 5'(RSP_LEN_SHORT - 1);

    // Frame byte selected by the tx byte counter; the last byte carries the CRC
    always_comb begin
        w_tx_byte = '0;
        case (r_cnt)
            5'd0:    w_tx_byte = {2'b01, r_index};
            5'd1:    w_tx_byte = r_arg[31:24];
            5'd2:    w_tx_byte = r_arg[23:16];
            5'd3:    w_tx_byte = r_arg[15:8];
            5'd4:    w_tx_byte = r_arg[7:0];
            default: w_tx_byte = {r_crc, 1'b1};
        endcase
    end

    sd_crc7_byte u_crc (
        .i_crc  (r_crc),
        .i_data (w_tx_byte),
        .o_crc  (w_crc_next)
    );

    // Command FSM: every non-idle state performs exactly one bus access, issued
    // from a cycle with cyc low, so an idle cycle always separates accesses
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_arg       <= '0;
            r_has_rsp   <= 1'b0;
            r_rsp_long  <= 1'b0;
            r_cnt       <= '0;
            r_crc       <= '0;
            r_wait      <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_we_o    <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
            bus_err_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_cnt_o   <= '0;
        end else begin
            done_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_start_i) begin
                        r_index    <= cmd_index_i;
                        r_arg      <= cmd_arg_i;
                        r_has_rsp  <= (rsp_type_i == 2'd1) || (rsp_type_i == 2'd2);
                        r_rsp_long <= (rsp_type_i == 2'd2);
                        r_cnt      <= '0;
                        r_crc      <= '0;
                        busy_o     <= 1'b1;
                        timeout_o  <= 1'b0;
                        bus_err_o  <= 1'b0;
                        r_state    <= S_ST_TX;
                    end
                end
                S_DONE: begin
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        r_wait    <= '0;
                        case (r_state)
                            S_WR_TX: begin
                                wbm_adr_o <= ADR_TX_CMD;
                                wbm_dat_o <= w_tx_byte;
                                wbm_we_o  <= 1'b1;
                            end
                            S_RD_TIM: wbm_adr_o <= ADR_TIMER;
                            S_RD_RX:  wbm_adr_o <= ADR_RX_CMD;
                            default:  wbm_adr_o <= ADR_STATUS;
                        endcase
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        case (r_state)
                            S_ST_TX: begin
                                if (!wbm_dat_i[STAT_TX_FULL]) r_state <= S_WR_TX;
                            end
                            S_WR_TX: begin
                                if (r_cnt == 5'(FRAME_LEN - 1)) begin
                                    r_cnt   <= '0;
                                    r_state <= r_has_rsp ? S_RX_STAT : S_DONE;
                                end else begin
                                    r_crc   <= w_crc_next;
                                    r_cnt   <= r_cnt + 5'd1;
                                    r_state <= S_ST_TX;
                                end
                            end
                            S_RX_STAT: begin
                                r_state <= wbm_dat_i[STAT_RX_EMPTY] ? S_RD_TIM : S_RD_RX;
                            end
                            S_RD_TIM: begin
                                if (wbm_dat_i == 8'd0) begin
                                    timeout_o <= 1'b1;
                                    r_state   <= S_DONE;
                                end else begin
                                    r_state   <= S_RX_STAT;
                                end
                            end
                            S_RD_RX: begin
                                rsp_valid_o <= 1'b1;
                                rsp_data_o  <= wbm_dat_i;
                                rsp_cnt_o   <= r_cnt;
                                if (r_cnt == w_last) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_cnt   <= r_cnt + 5'd1;
                                    r_state <= S_RX_STAT;
                                end
                            end
                            default: r_state <= S_DONE;
                        endcase
                    end else if (r_wait == WAIT_W'(ACK_WAIT_MAX - 1)) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        bus_err_o <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_wb_master.sv
// Bench for sd_cmd_wb_master: Wishbone slave model with scripted FIFO/timer
// behaviour, reference frame built from a polynomial-division CRC7.
module tb_sd_cmd_wb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  wbm_adr_o;
    logic [7:0]  wbm_dat_o;
    logic [7:0]  wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;
    logic        cmd_start_i;
    logic [5:0]  cmd_index_i;
    logic [31:0] cmd_arg_i;
    logic [1:0]  rsp_type_i;
    logic        busy_o, done_o, timeout_o, bus_err_o, rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic [4:0]  rsp_cnt_o;

    sd_cmd_wb_master #(.ACK_WAIT_MAX(15)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
        .cmd_start_i(cmd_start_i), .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i),
        .rsp_type_i(rsp_type_i), .busy_o(busy_o), .done_o(done_o),
        .timeout_o(timeout_o), .bus_err_o(bus_err_o), .rsp_valid_o(rsp_valid_o),
        .rsp_data_o(rsp_data_o), .rsp_cnt_o(rsp_cnt_o)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Slave model configuration and observations
    int unsigned ack_delay = 1;
    bit          no_ack    = 0;
    int unsigned full_at   = 99;
    int unsigned full_left = 0;
    int unsigned gap_cur   = 0;
    logic [7:0]  rx_q[$];
    int unsigned gap_q[$];
    logic [7:0]  timer_q[$];
    logic [7:0]  tx_q[$];
    int unsigned st_tx_reads, st_rx_reads, tim_reads, rx_reads, viol;
    bit          last_full;

    // Monitor observations
    logic [7:0]  rsp_q[$];
    logic [4:0]  cnt_q[$];
    int unsigned done_cnt, cyc_run, max_run;
    bit          seen_tmo, seen_berr;

    // Reference expectations
    logic [7:0]  exp_rsp[$];
    int unsigned gap_sum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'b1000_1001;
        return r[6:0];
    endfunction

    function automatic int unsigned rsp_len(input logic [1:0] rt);
        return (rt == 2'd1) ? 6 : (rt == 2'd2) ? 17 : 0;
    endfunction

    // Wishbone slave: acks after ack_delay cycles, one-cycle ack pulse
    initial begin
        int unsigned dcnt;
        logic [7:0]  v;
        dcnt = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                wbm_ack_i <= 1'b0;
                dcnt = 0;
            end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !no_ack) begin
                if (dcnt >= ack_delay) begin
                    dcnt = 0;
                    wbm_ack_i <= 1'b1;
                    v = 8'h00;
                    if (wbm_we_o) begin
                        if (wbm_adr_o != 3'd0 || last_full) viol++;
                        tx_q.push_back(wbm_dat_o);
                    end else begin
                        case (wbm_adr_o)
                            3'd4: begin
                                last_full = (tx_q.size() == full_at) && (full_left > 0);
                                if (last_full) full_left--;
                                v = {6'b0, (rx_q.size() == 0) || (gap_cur > 0), last_full};
                                if (tx_q.size() < 6) st_tx_reads++; else st_rx_reads++;
                            end
                            3'd6: begin
                                tim_reads++;
                                v = (timer_q.size() > 0) ? timer_q.pop_front() : 8'd50;
                                if (gap_cur > 0) gap_cur--;
                            end
                            3'd1: begin
                                rx_reads++;
                                if (rx_q.size() == 0 || gap_cur > 0) viol++;
                                else v = rx_q.pop_front();
                                gap_cur = (gap_q.size() > 0) ? gap_q.pop_front() : 0;
                            end
                            default: viol++;
                        endcase
                    end
                    wbm_dat_i <= v;
                end else begin
                    dcnt++;
                end
            end else begin
                wbm_ack_i <= 1'b0;
                if (!wbm_cyc_o) dcnt = 0;
            end
        end
    end

    // Protocol and output monitor, sampled on the falling edge
    initial begin
        bit         p_ack, p_cyc, p_we;
        logic [2:0] p_adr;
        logic [7:0] p_dat;
        p_ack = 0; p_cyc = 0; p_we = 0; p_adr = '0; p_dat = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (p_ack && wbm_cyc_o) viol++;
                if (wbm_cyc_o && p_cyc && !p_ack &&
                    (wbm_adr_o != p_adr || wbm_we_o != p_we || wbm_dat_o != p_dat)) viol++;
                if (wbm_cyc_o != wbm_stb_o) viol++;
                cyc_run = wbm_cyc_o ? cyc_run + 1 : 0;
                if (cyc_run > max_run) max_run = cyc_run;
                if (rsp_valid_o) begin
                    rsp_q.push_back(rsp_data_o);
                    cnt_q.push_back(rsp_cnt_o);
                end
                if (done_o) begin
                    done_cnt++;
                    seen_tmo  = timeout_o;
                    seen_berr = bus_err_o;
                end
            end
            p_ack = wbm_ack_i; p_cyc = wbm_cyc_o; p_we = wbm_we_o;
            p_adr = wbm_adr_o; p_dat = wbm_dat_o;
        end
    end

    task automatic setup_rsp(input int unsigned n, input int unsigned maxgap);
        int unsigned g;
        logic [7:0]  b;
        rx_q.delete(); gap_q.delete(); exp_rsp.delete();
        gap_sum = 0;
        for (int unsigned i = 0; i < n; i++) begin
            b = 8'($urandom);
            g = $urandom_range(maxgap, 0);
            rx_q.push_back(b);
            exp_rsp.push_back(b);
            gap_q.push_back(g);
            gap_sum += g;
        end
        gap_cur = (gap_q.size() > 0) ? gap_q.pop_front() : 0;
    endtask

    task automatic clear_obs();
        tx_q.delete(); rsp_q.delete(); cnt_q.delete();
        st_tx_reads = 0; st_rx_reads = 0; tim_reads = 0; rx_reads = 0; viol = 0;
        done_cnt = 0; max_run = 0; seen_tmo = 0; seen_berr = 0; last_full = 0;
    endtask

    task automatic pulse_start(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
        @(negedge clk);
        cmd_index_i = idx; cmd_arg_i = arg; rsp_type_i = rt; cmd_start_i = 1'b1;
        @(negedge clk);
        cmd_start_i = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] rt, input bit exp_tmo, input int unsigned mid_at);
        logic [7:0]  fr[6];
        int unsigned n_rsp, exp_full, n_tim;
        clear_obs();
        exp_full = full_left;
        n_tim    = timer_q.size();
        n_rsp    = exp_tmo ? 0 : rsp_len(rt);
        fr[0] = {2'b01, idx};
        fr[1] = arg[31:24]; fr[2] = arg[23:16]; fr[3] = arg[15:8]; fr[4] = arg[7:0];
        fr[5] = {crc7_ref({fr[0], fr[1], fr[2], fr[3], fr[4]}), 1'b1};

        pulse_start(idx, arg, rt);
        check({tag, " busy"}, 32'(busy_o), 32'd1);
        for (int unsigned c = 0; c < 4000 && done_cnt == 0; c++) begin
            @(negedge clk);
            cmd_start_i = (mid_at != 0 && c == mid_at);
            if (cmd_start_i) begin
                cmd_index_i = 6'h3F; cmd_arg_i = 32'hFFFF_FFFF; rsp_type_i = 2'd1;
            end
        end
        cmd_start_i = 1'b0;
        check({tag, " done"}, done_cnt, 1);
        check({tag, " timeout"}, 32'(seen_tmo), 32'(exp_tmo));
        check({tag, " bus_err"}, 32'(seen_berr), 32'd0);
        check({tag, " tx count"}, tx_q.size(), 6);
        for (int unsigned i = 0; i < 6; i++)
            if (i < tx_q.size()) check($sformatf("%s tx[%0d]", tag, i), 32'(tx_q[i]), 32'(fr[i]));
        check({tag, " tx status reads"}, st_tx_reads, 6 + exp_full);
        check({tag, " rx status reads"}, st_rx_reads,
              exp_tmo ? n_tim : (rsp_len(rt) == 0 ? 0 : n_rsp + gap_sum));
        check({tag, " timer reads"}, tim_reads, exp_tmo ? n_tim : (rsp_len(rt) == 0 ? 0 : gap_sum));
        check({tag, " rx reads"}, rx_reads, n_rsp);
        check({tag, " rsp count"}, rsp_q.size(), n_rsp);
        for (int unsigned i = 0; i < n_rsp && i < rsp_q.size(); i++) begin
            check($sformatf("%s rsp[%0d]", tag, i), 32'(rsp_q[i]), 32'(exp_rsp[i]));
            check($sformatf("%s cnt[%0d]", tag, i), 32'(cnt_q[i]), i);
        end
        check({tag, " protocol"}, viol, 0);
        repeat (20) @(negedge clk);
        check({tag, " idle after"}, {31'd0, busy_o}, 32'd0);
        check({tag, " no extra cmd"}, tx_q.size() + done_cnt, 7);
    endtask

    initial begin
        logic [1:0] rt;
        rst = 1'b1;
        cmd_start_i = 1'b0; cmd_index_i = '0; cmd_arg_i = '0; rsp_type_i = '0;
        clear_obs();
        repeat (3) @(negedge clk);
        check("reset outputs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, busy_o,
              done_o, timeout_o, bus_err_o, rsp_valid_o, rsp_data_o, rsp_cnt_o}, 32'd0);
        check("reset sel", 32'(wbm_sel_o), 32'hF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CMD0, no response, 2-cycle ack
        ack_delay = 2; setup_rsp(0, 0); timer_q.delete();
        run_cmd("cmd0", 6'd0, 32'h0, 2'd0, 1'b0, 0);
        check("cmd0 crc byte", 32'(tx_q[5]), 32'h95);

        // CMD8, short response
        ack_delay = 1; setup_rsp(6, 0);
        rx_q = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
        exp_rsp = rx_q;
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 2'd1, 1'b0, 0);
        check("cmd8 crc byte", 32'(tx_q[5]), 32'h87);

        // tx FIFO full for 10 status reads before byte 3
        full_at = 3; full_left = 10; setup_rsp(6, 1);
        run_cmd("txfull", 6'd17, 32'hDEAD_BEEF, 2'd1, 1'b0, 0);
        full_at = 99; full_left = 0;

        // Response timeout: rx never fills, timer counts down
        setup_rsp(0, 0); timer_q = '{8'd3, 8'd2, 8'd1, 8'd0};
        run_cmd("timeout", 6'd55, 32'h1234_5678, 2'd1, 1'b1, 0);
        timer_q.delete();

        // Long response with a start pulse mid-transfer
        ack_delay = 0; setup_rsp(17, 2);
        run_cmd("long", 6'd2, 32'h0, 2'd2, 1'b0, 60);

        // Randomized commands
        for (int unsigned t = 0; t < 8; t++) begin
            rt = 2'($urandom);
            ack_delay = $urandom_range(3, 0);
            full_at   = $urandom_range(5, 0);
            full_left = $urandom_range(4, 0);
            setup_rsp(rsp_len(rt), 2);
            run_cmd($sformatf("rand%0d", t), 6'($urandom), $urandom, rt, 1'b0, 0);
        end
        full_at = 99; full_left = 0;

        // Ack watchdog: slave never acks
        clear_obs(); no_ack = 1;
        pulse_start(6'd0, 32'h0, 2'd0);
        for (int unsigned c = 0; c < 200 && done_cnt == 0; c++) @(negedge clk);
        check("berr done", done_cnt, 1);
        check("berr flag", 32'(seen_berr), 32'd1);
        check("berr timeout", 32'(seen_tmo), 32'd0);
        check("berr cyc cycles", max_run, 15);
        check("berr no write", tx_q.size(), 0);
        no_ack = 0;

        // Asynchronous reset in the middle of a transfer
        clear_obs(); ack_delay = 1; setup_rsp(17, 1);
        pulse_start(6'd9, 32'hA5A5_5A5A, 2'd2);
        repeat (25) @(negedge clk);
        check("pre-reset busy", 32'(busy_o), 32'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async reset outputs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, busy_o,
              done_o, timeout_o, bus_err_o, rsp_valid_o, rsp_data_o, rsp_cnt_o}, 32'd0);
        check("async reset sel", 32'(wbm_sel_o), 32'hF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("no done after reset", done_cnt, 0);
        check("idle after reset", {30'd0, wbm_cyc_o, busy_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
